// File: rtl/reg_bank_pkg.sv
// Shared types and helpers for the reg_bank register file.
// Optional same-cycle forwarding is enabled by defining REG_BANK_BYPASS_EN.
package reg_bank_pkg;

  typedef enum logic {
    CLEAR = 1'b0,
    RUN   = 1'b1
  } state_t;

  function automatic int depth(input int addr_w);
    return 1 << addr_w;
  endfunction

endpackage

// Slice port k out of a packed multi-port bus whose ports are w bits wide.
`define RB_PORT(bus, k, w) bus[(k)*(w) +: (w)]

// File: rtl/reg_bank_if.sv
// Write/read bus of the register file. The master drives writes and read
// addresses; the slave (reg_bank) returns read data, hi/lo and busy.
interface reg_bank_if #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 6,
  parameter int NUM_READ = 3
);
  logic                         write_en;
  logic                         write_wide;
  logic [ADDR_W-1:0]            write_adr;
  logic [DATA_W-1:0]            write_data;
  logic [2*DATA_W-1:0]          write_data_wide;
  logic [NUM_READ*ADDR_W-1:0]   read_adr;
  logic [NUM_READ*DATA_W-1:0]   read_data;
  logic [DATA_W-1:0]            hi;
  logic [DATA_W-1:0]            lo;
  logic                         busy;

  modport master (
    output write_en, write_wide, write_adr, write_data, write_data_wide, read_adr,
    input  read_data, hi, lo, busy
  );

  modport slave (
    input  write_en, write_wide, write_adr, write_data, write_data_wide, read_adr,
    output read_data, hi, lo, busy
  );
endinterface

// File: rtl/reg_bank_clear_seq.sv
// Post-reset clear sequencer: walks every array entry once, writing zero,
// and holds busy high until the last entry has been cleared.
module reg_bank_clear_seq
  import reg_bank_pkg::*;
#(
  parameter int ADDR_W = 6
) (
  input  logic              clock,
  input  logic              reset_n,
  output logic              clr_we,
  output logic [ADDR_W-1:0] clr_adr,
  output logic              busy
);

  localparam logic [ADDR_W-1:0] LAST_ADR = '1;

  state_t            state;
  state_t            state_nxt;
  logic [ADDR_W-1:0] clr_ptr;
  logic [ADDR_W-1:0] ptr_nxt;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state   <= CLEAR;
      clr_ptr <= '0;
    end else begin
      state   <= state_nxt;
      clr_ptr <= ptr_nxt;
    end
  end

  // NOTE: every combinational output gets a default first so no latch is inferred.
  always_comb begin
    state_nxt = state;
    ptr_nxt   = clr_ptr;
    if (state == CLEAR) begin
      ptr_nxt = clr_ptr + ADDR_W'(1);
      if (clr_ptr == LAST_ADR) state_nxt = RUN;
    end
  end

  // Nothing is cleared while reset is still asserted; the walk starts on release.
  always_comb begin
    busy    = (state == CLEAR);
    clr_we  = busy && reset_n;
    clr_adr = clr_ptr;
  end

endmodule

// File: rtl/reg_bank.sv
// Parametrised register file with HI/LO wide-write pair and NUM_READ
// combinational read ports. Define REG_BANK_BYPASS_EN for same-cycle forwarding.
module reg_bank
  import reg_bank_pkg::*;
#(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 6,
  parameter int NUM_READ = 3,
  parameter int LO_IDX   = 3,
  parameter int HI_IDX   = 4,
  parameter int ZERO_R0  = 1
) (
  input  logic      clock,
  input  logic      reset_n,
  reg_bank_if.slave bus
);

  localparam int                DEPTH = depth(ADDR_W);
  localparam logic [ADDR_W-1:0] LO_A  = ADDR_W'(LO_IDX);
  localparam logic [ADDR_W-1:0] HI_A  = ADDR_W'(HI_IDX);

  if (LO_IDX == HI_IDX) begin : g_idx_check
    $error("reg_bank: LO_IDX and HI_IDX must name different entries");
  end

  logic              clr_we;
  logic [ADDR_W-1:0] clr_adr;
  logic              busy;
  logic              run_we;
  logic              narrow_we;
  logic              wide_we;
  logic [DATA_W-1:0] wide_lo;
  logic [DATA_W-1:0] wide_hi;
  logic [DATA_W-1:0] regs [DEPTH];

  reg_bank_clear_seq #(.ADDR_W(ADDR_W)) u_clear_seq (
    .clock   (clock),
    .reset_n (reset_n),
    .clr_we  (clr_we),
    .clr_adr (clr_adr),
    .busy    (busy)
  );

  assign wide_lo   = bus.write_data_wide[DATA_W-1:0];
  assign wide_hi   = bus.write_data_wide[2*DATA_W-1:DATA_W];
  assign run_we    = bus.write_en && !busy && reset_n;
  assign narrow_we = run_we && !bus.write_wide && !((ZERO_R0 != 0) && (bus.write_adr == '0));
  assign wide_we   = run_we && bus.write_wide;

  // NOTE: the array has no reset branch; zeroing is done entry by entry by the sequencer.
  always_ff @(posedge clock) begin
    if (clr_we) begin
      regs[clr_adr] <= '0;
    end else begin
      if (narrow_we) regs[bus.write_adr] <= bus.write_data;
      if (wide_we) begin
        regs[LO_A] <= wide_lo;
        regs[HI_A] <= wide_hi;
      end
    end
  end

  // Busy and the hard-wired zero entry override both stored and forwarded data.
  function automatic logic [DATA_W-1:0] read_entry(input logic [ADDR_W-1:0] adr);
    logic [DATA_W-1:0] val;
    val = regs[adr];
`ifdef REG_BANK_BYPASS_EN
    if (narrow_we && (adr == bus.write_adr)) val = bus.write_data;
    else if (wide_we && (adr == LO_A))       val = wide_lo;
    else if (wide_we && (adr == HI_A))       val = wide_hi;
`endif
    if (busy || ((ZERO_R0 != 0) && (adr == '0))) val = '0;
    return val;
  endfunction

  for (genvar k = 0; k < NUM_READ; k++) begin : g_rd
    assign `RB_PORT(bus.read_data, k, DATA_W) = read_entry(`RB_PORT(bus.read_adr, k, ADDR_W));
  end

  assign bus.hi   = read_entry(HI_A);
  assign bus.lo   = read_entry(LO_A);
  assign bus.busy = busy;

endmodule

// File: tb/tb_reg_bank.sv
// Self-checking bench for reg_bank: directed vector table, hand-written reset/clear
// sequences and randomized traffic checked against an array-based reference model.
module tb_reg_bank;

  localparam int DATA_W   = 32;
  localparam int ADDR_W   = 6;
  localparam int NUM_READ = 3;
  localparam int DEPTH    = 64;
  localparam int LO_IDX   = 3;
  localparam int HI_IDX   = 4;
`ifdef REG_BANK_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  typedef struct {
    logic                              rst_n;
    logic                              we;
    logic                              wide;
    logic [ADDR_W-1:0]                 wadr;
    logic [DATA_W-1:0]                 wdata;
    logic [2*DATA_W-1:0]               wwide;
    logic [NUM_READ-1:0][ADDR_W-1:0]   radr;
  } stim_t;

  typedef struct {
    stim_t                             s;
    logic [NUM_READ-1:0][DATA_W-1:0]   exp_rd;
    logic [DATA_W-1:0]                 exp_hi;
    logic [DATA_W-1:0]                 exp_lo;
  } vec_t;

  logic clock   = 1'b0;
  logic reset_n = 1'b0;
  always #5 clock = ~clock;

  reg_bank_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .NUM_READ(NUM_READ)) bus_if ();

  reg_bank #(
    .DATA_W(DATA_W), .ADDR_W(ADDR_W), .NUM_READ(NUM_READ),
    .LO_IDX(LO_IDX), .HI_IDX(HI_IDX), .ZERO_R0(1)
  ) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (bus_if)
  );

  int checks   = 0;
  int failures = 0;

  // Reference model: plain array plus a busy countdown.
  logic [DATA_W-1:0] m_regs [DEPTH];
  bit                m_busy = 1'b1;
  int                m_left = DEPTH;
  logic              last_busy;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: actual=%h required=%h", name, act, exp);
    end
  endtask

  function automatic stim_t mk(input logic rst_n, input logic we, input logic wide,
                               input int wadr, input logic [DATA_W-1:0] wdata,
                               input logic [2*DATA_W-1:0] wwide,
                               input int r0, input int r1, input int r2);
    stim_t s;
    s.rst_n   = rst_n;
    s.we      = we;
    s.wide    = wide;
    s.wadr    = ADDR_W'(wadr);
    s.wdata   = wdata;
    s.wwide   = wwide;
    s.radr[0] = ADDR_W'(r0);
    s.radr[1] = ADDR_W'(r1);
    s.radr[2] = ADDR_W'(r2);
    return s;
  endfunction

  function automatic stim_t idle(input logic rst_n);
    return mk(rst_n, 1'b0, 1'b0, $urandom_range(0, DEPTH-1), $urandom, {$urandom, $urandom},
              $urandom_range(0, DEPTH-1), $urandom_range(0, DEPTH-1), $urandom_range(0, DEPTH-1));
  endfunction

  function automatic logic [DATA_W-1:0] model_read(input logic [ADDR_W-1:0] adr, input stim_t s);
    if (m_busy || adr == 0) return '0;
    if (BYP && s.we && s.rst_n) begin
      if (!s.wide && adr == s.wadr) return s.wdata;
      if (s.wide && adr == LO_IDX)  return s.wwide[DATA_W-1:0];
      if (s.wide && adr == HI_IDX)  return s.wwide[2*DATA_W-1:DATA_W];
    end
    return m_regs[adr];
  endfunction

  task automatic drive(input stim_t s);
    reset_n                = s.rst_n;
    bus_if.write_en        = s.we;
    bus_if.write_wide      = s.wide;
    bus_if.write_adr       = s.wadr;
    bus_if.write_data      = s.wdata;
    bus_if.write_data_wide = s.wwide;
    bus_if.read_adr        = s.radr;
    #3;
    last_busy = bus_if.busy;
  endtask

  task automatic model_compare(input stim_t s, input string tag);
    for (int k = 0; k < NUM_READ; k++)
      check($sformatf("%s rd%0d adr=%0d", tag, k, s.radr[k]),
            64'(bus_if.read_data[k*DATA_W +: DATA_W]), 64'(model_read(s.radr[k], s)));
    check({tag, " hi"},   64'(bus_if.hi),   64'(model_read(ADDR_W'(HI_IDX), s)));
    check({tag, " lo"},   64'(bus_if.lo),   64'(model_read(ADDR_W'(LO_IDX), s)));
    check({tag, " busy"}, 64'(bus_if.busy), 64'(m_busy));
  endtask

  task automatic finish_cycle(input stim_t s);
    @(posedge clock);
    if (!s.rst_n) begin
      m_busy = 1'b1;
      m_left = DEPTH;
    end else if (m_busy) begin
      m_left--;
      if (m_left == 0) begin
        m_busy = 1'b0;
        foreach (m_regs[i]) m_regs[i] = '0;
      end
    end else if (s.we) begin
      if (s.wide) begin
        m_regs[LO_IDX] = s.wwide[DATA_W-1:0];
        m_regs[HI_IDX] = s.wwide[2*DATA_W-1:DATA_W];
      end else if (s.wadr != 0) begin
        m_regs[s.wadr] = s.wdata;
      end
    end
    #1;
  endtask

  task automatic run_cycle(input stim_t s, input string tag);
    drive(s);
    model_compare(s, tag);
    finish_cycle(s);
  endtask

  // Counts cycles with busy high after release; optional write pulses land mid-clear.
  task automatic count_busy(input string tag, input bit with_writes);
    int    cnt;
    stim_t s;
    cnt = 0;
    for (int i = 0; i < 200; i++) begin
      s = idle(1'b1);
      if (with_writes && cnt == 5)  s = mk(1, 1, 0, 10, 32'hCAFE_F00D, '0, 10, 2, 5);
      if (with_writes && cnt == 40) s = mk(1, 1, 0, 2,  32'h0BAD_0BAD, '0, 2, 10, 5);
      drive(s);
      model_compare(s, tag);
      finish_cycle(s);
      if (last_busy !== 1'b1) break;
      cnt++;
    end
    check({tag, " busy cycles"}, 64'(cnt), 64'(DEPTH));
  endtask

  vec_t  tbl [9];
  stim_t s;
  logic [ADDR_W-1:0] last_wadr;

  initial begin
    foreach (m_regs[i]) m_regs[i] = '0;
    last_wadr = '0;

    // Directed vectors, applied from the all-zero state left by the clear sequence.
    tbl[0] = '{mk(1,1,0,7,32'hDEAD_BEEF,'0,7,7,7),
               {3{BYP ? 32'hDEAD_BEEF : 32'h0}}, 32'h0, 32'h0};
    tbl[1] = '{mk(1,0,0,0,'0,'0,7,0,9),
               {32'h0, 32'h0, 32'hDEAD_BEEF}, 32'h0, 32'h0};
    tbl[2] = '{mk(1,1,1,9,32'h55,64'h1234_5678_9ABC_DEF0,3,4,9),
               {32'h0, BYP ? 32'h1234_5678 : 32'h0, BYP ? 32'h9ABC_DEF0 : 32'h0},
               BYP ? 32'h1234_5678 : 32'h0, BYP ? 32'h9ABC_DEF0 : 32'h0};
    tbl[3] = '{mk(1,0,0,0,'0,'0,3,4,9),
               {32'h0, 32'h1234_5678, 32'h9ABC_DEF0}, 32'h1234_5678, 32'h9ABC_DEF0};
    tbl[4] = '{mk(1,1,0,0,32'hFFFF_FFFF,'0,0,0,0),
               {3{32'h0}}, 32'h1234_5678, 32'h9ABC_DEF0};
    tbl[5] = '{mk(1,0,0,0,'0,'0,0,0,0),
               {3{32'h0}}, 32'h1234_5678, 32'h9ABC_DEF0};
    tbl[6] = '{mk(1,1,0,5,32'h1111_2222,'0,5,7,3),
               {32'h9ABC_DEF0, 32'hDEAD_BEEF, BYP ? 32'h1111_2222 : 32'h0},
               32'h1234_5678, 32'h9ABC_DEF0};
    tbl[7] = '{mk(1,1,0,5,32'hAAAA_5555,'0,5,5,5),
               {3{BYP ? 32'hAAAA_5555 : 32'h1111_2222}}, 32'h1234_5678, 32'h9ABC_DEF0};
    tbl[8] = '{mk(1,0,0,0,'0,'0,5,5,5),
               {3{32'hAAAA_5555}}, 32'h1234_5678, 32'h9ABC_DEF0};

    // Reset held low 3 cycles; the first edge only establishes a known state.
    drive(idle(1'b0));
    finish_cycle(idle(1'b0));
    for (int i = 0; i < 2; i++) run_cycle(idle(1'b0), "reset");
    count_busy("clear", 1'b0);

    for (int i = 0; i < (DEPTH + 2) / 3; i++) begin
      s = mk(1, 0, 0, 0, '0, '0, (3*i) % DEPTH, (3*i+1) % DEPTH, (3*i+2) % DEPTH);
      drive(s);
      for (int k = 0; k < NUM_READ; k++)
        check($sformatf("cleared adr=%0d", s.radr[k]),
              64'(bus_if.read_data[k*DATA_W +: DATA_W]), 64'h0);
      finish_cycle(s);
    end

    foreach (tbl[v]) begin
      drive(tbl[v].s);
      for (int k = 0; k < NUM_READ; k++)
        check($sformatf("vec%0d rd%0d", v, k),
              64'(bus_if.read_data[k*DATA_W +: DATA_W]), 64'(tbl[v].exp_rd[k]));
      check($sformatf("vec%0d hi", v),   64'(bus_if.hi),   64'(tbl[v].exp_hi));
      check($sformatf("vec%0d lo", v),   64'(bus_if.lo),   64'(tbl[v].exp_lo));
      check($sformatf("vec%0d busy", v), 64'(bus_if.busy), 64'h0);
      model_compare(tbl[v].s, $sformatf("vec%0d model", v));
      finish_cycle(tbl[v].s);
    end

    // Randomized traffic with occasional reset, reads biased toward recent writes.
    for (int i = 0; i < 600; i++) begin
      s       = idle(1'b1);
      s.rst_n = ($urandom_range(0, 249) != 0);
      s.we    = s.rst_n && ($urandom_range(0, 1) == 1);
      s.wide  = ($urandom_range(0, 5) == 0);
      for (int k = 0; k < NUM_READ; k++)
        case ($urandom_range(0, 3))
          0, 1: s.radr[k] = last_wadr;
          2:    s.radr[k] = ADDR_W'($urandom_range(LO_IDX, HI_IDX));
          default: ;
        endcase
      if (s.we && !s.wide) last_wadr = s.wadr;
      run_cycle(s, $sformatf("rand%0d", i));
    end

    // Reset pulse at clr_ptr=20 restarts the clear; writes during busy are dropped.
    run_cycle(idle(1'b0), "restart rst");
    for (int i = 0; i < 20; i++) run_cycle(idle(1'b1), "restart pre");
    run_cycle(idle(1'b0), "restart pulse");
    count_busy("restart", 1'b1);
    s = mk(1, 0, 0, 0, '0, '0, 10, 2, 0);
    drive(s);
    check("dropped write adr=10", 64'(bus_if.read_data[0 +: DATA_W]), 64'h0);
    check("dropped write adr=2",  64'(bus_if.read_data[DATA_W +: DATA_W]), 64'h0);
    model_compare(s, "restart post");
    finish_cycle(s);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
